// File: rtl/invalid_range_scanner_pkg.sv
// Shared constants for the invalid-ID range scanner: powers of ten, repeat multipliers,
// first-candidate and scan-length tables, pass plan entry type and FSM states.
package invalid_scan_pkg;

    localparam int MAX_DIG_LIM = 12;

    typedef logic [MAX_DIG_LIM:0][63:0]                 pow10Tab_t;
    typedef logic [MAX_DIG_LIM:0][MAX_DIG_LIM:0][63:0]  repTab_t;

    typedef struct packed {
        logic [3:0] p;
        logic       sign;   // 1 = subtract this pass from the totals
    } pass_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCAN,
        ST_DONE
    } scanState_t;

    function automatic pow10Tab_t buildPow10();
        pow10Tab_t t;
        t[0] = 64'd1;
        for (int i = 1; i <= MAX_DIG_LIM; i++) begin
            t[i] = t[i-1] * 64'd10;
        end
        return t;
    endfunction

    localparam pow10Tab_t POW10 = buildPow10();

    // M = (10^L-1)/(10^p-1), formed as 1 + 10^p + 10^2p + ... so no division is needed.
    function automatic repTab_t buildRepMult();
        repTab_t     t;
        logic [63:0] m;
        t = '0;
        for (int l = 1; l <= MAX_DIG_LIM; l++) begin
            for (int p = 1; p <= l; p++) begin
                if (l % p == 0) begin
                    m = 64'd0;
                    for (int i = 0; i < l / p; i++) begin
                        m = m * POW10[p] + 64'd1;
                    end
                    t[l][p] = m;
                end
            end
        end
        return t;
    endfunction

    localparam repTab_t REP_MULT = buildRepMult();

    function automatic repTab_t buildStartCand();
        repTab_t t;
        t = '0;
        for (int l = 1; l <= MAX_DIG_LIM; l++) begin
            for (int p = 1; p <= l; p++) begin
                if (l % p == 0) begin
                    t[l][p] = REP_MULT[l][p] * POW10[p-1];
                end
            end
        end
        return t;
    endfunction

    localparam repTab_t START_CAND = buildStartCand();

    function automatic pow10Tab_t buildScanLen();
        pow10Tab_t t;
        t[0] = 64'd0;
        for (int p = 1; p <= MAX_DIG_LIM; p++) begin
            t[p] = POW10[p-1] * 64'd9;
        end
        return t;
    endfunction

    localparam pow10Tab_t SCAN_LEN = buildScanLen();

endpackage

// File: rtl/invalid_range_scanner_pass_plan.sv
// Pass plan for one digit length: block lengths with add/subtract sign, adds first.
// Purely combinational; an empty plan is reported as nPass = 0.
module inv_pass_plan
    import invalid_scan_pkg::*;
(
    input  logic [3:0]      digLen,
    input  logic            mode,
    output pass_t [2:0]     plan,
    output logic  [1:0]     nPass
);

    function automatic pass_t mkPass(input logic [3:0] p, input logic sign);
        pass_t e;
        e.p    = p;
        e.sign = sign;
        return e;
    endfunction

    always_comb begin
        plan  = '0;
        nPass = 2'd0;
        if (!mode) begin
            if (digLen != 4'd0 && !digLen[0]) begin
                plan[0] = mkPass({1'b0, digLen[3:1]}, 1'b0);
                nPass   = 2'd1;
            end
        end else begin
            // One add pass per prime factor q (p = L/q); two primes add a p = L/(q1*q2) subtract.
            case (digLen)
                4'd2, 4'd3, 4'd5, 4'd7, 4'd11: begin
                    plan[0] = mkPass(4'd1, 1'b0);
                    nPass   = 2'd1;
                end
                4'd4: begin
                    plan[0] = mkPass(4'd2, 1'b0);
                    nPass   = 2'd1;
                end
                4'd8: begin
                    plan[0] = mkPass(4'd4, 1'b0);
                    nPass   = 2'd1;
                end
                4'd9: begin
                    plan[0] = mkPass(4'd3, 1'b0);
                    nPass   = 2'd1;
                end
                4'd6: begin
                    plan[0] = mkPass(4'd3, 1'b0);
                    plan[1] = mkPass(4'd2, 1'b0);
                    plan[2] = mkPass(4'd1, 1'b1);
                    nPass   = 2'd3;
                end
                4'd10: begin
                    plan[0] = mkPass(4'd5, 1'b0);
                    plan[1] = mkPass(4'd2, 1'b0);
                    plan[2] = mkPass(4'd1, 1'b1);
                    nPass   = 2'd3;
                end
                4'd12: begin
                    plan[0] = mkPass(4'd6, 1'b0);
                    plan[1] = mkPass(4'd4, 1'b0);
                    plan[2] = mkPass(4'd2, 1'b1);
                    nPass   = 2'd3;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/invalid_range_scanner.sv
// Sums and counts repeated-block IDs of one digit length inside [lo,hi], one candidate per cycle.
// Latency 1 + sum(1 + 9*10^(p-1)) per pass; start is ignored unless the FSM is idle.
module invalid_range_scanner
    import invalid_scan_pkg::*;
#(
    parameter int W       = 40,
    parameter int MAX_DIG = 10,
    parameter int SUM_W   = 56,
    parameter int CNT_W   = 24
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             accum,
    input  logic [3:0]       dig_len,
    input  logic [W-1:0]     lo,
    input  logic [W-1:0]     hi,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum_out,
    output logic [CNT_W-1:0] cnt_out,
    output logic             ovf,
    output logic             err
);

    localparam int AW = ((SUM_W > W) ? SUM_W : W) + 1;

    scanState_t      state;
    logic            modeR;
    logic [3:0]      lenR;
    logic [W-1:0]    loR;
    logic [W-1:0]    hiR;
    logic [W-1:0]    cand;
    logic [W-1:0]    mult;
    logic [W-1:0]    stepCnt;
    logic [1:0]      passIdx;
    logic            signR;

    pass_t [2:0]     plan;
    logic  [1:0]     nPass;
    pass_t           curPass;
    logic            illegalLen;
    logic            inRange;
    logic            lastPass;
    logic [2:0]      nextIdx;
    logic [AW-1:0]   sumExt;
    logic [AW-1:0]   candExt;
    logic [AW-1:0]   sumNext;
    logic            sumCarry;
    logic [CNT_W:0]  cntExt;
    logic            cntCarry;

    inv_pass_plan uPlan (
        .digLen (lenR),
        .mode   (modeR),
        .plan   (plan),
        .nPass  (nPass)
    );

    always_comb begin
        curPass    = plan[passIdx];
        illegalLen = (dig_len == 4'd0) || (int'(dig_len) > MAX_DIG);
        inRange    = (cand >= loR) && (cand <= hiR);
        nextIdx    = {1'b0, passIdx} + 3'd1;
        lastPass   = nextIdx >= {1'b0, nPass};
        sumExt     = AW'(sum_out);
        candExt    = AW'(cand);
        sumNext    = signR ? (sumExt - candExt) : (sumExt + candExt);
        // Wide adder so candidates wider than the sum still flag a wrap.
        sumCarry   = !signR && (sumNext[AW-1:SUM_W] != '0);
        cntExt     = signR ? ({1'b0, cnt_out} - (CNT_W+1)'(1))
                           : ({1'b0, cnt_out} + (CNT_W+1)'(1));
        cntCarry   = !signR && cntExt[CNT_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum_out <= '0;
            cnt_out <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            modeR   <= 1'b0;
            lenR    <= 4'd0;
            loR     <= '0;
            hiR     <= '0;
            cand    <= '0;
            mult    <= '0;
            stepCnt <= '0;
            passIdx <= 2'd0;
            signR   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        modeR   <= mode;
                        lenR    <= dig_len;
                        loR     <= lo;
                        hiR     <= hi;
                        passIdx <= 2'd0;
                        err     <= illegalLen;
                        if (!accum) begin
                            sum_out <= '0;
                            cnt_out <= '0;
                            ovf     <= 1'b0;
                        end
                        if (illegalLen) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_SETUP;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if ({1'b0, passIdx} >= {1'b0, nPass}) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        mult    <= REP_MULT[lenR][curPass.p][W-1:0];
                        cand    <= START_CAND[lenR][curPass.p][W-1:0];
                        stepCnt <= SCAN_LEN[curPass.p][W-1:0];
                        signR   <= curPass.sign;
                        state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (inRange) begin
                        sum_out <= sumNext[SUM_W-1:0];
                        cnt_out <= cntExt[CNT_W-1:0];
                        if (sumCarry || cntCarry) begin
                            ovf <= 1'b1;
                        end
                    end
                    cand    <= cand + mult;
                    stepCnt <= stepCnt - W'(1);
                    if (stepCnt == W'(1)) begin
                        if (lastPass) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            passIdx <= nextIdx[1:0];
                            state   <= ST_SETUP;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_invalid_range_scanner.sv
// Scoreboard bench: a digit-pattern model predicts totals, error and latency per job;
// a second instance with a 12-bit sum exercises wrap and the sticky overflow flag.
`timescale 1ns/1ps
module tb_invalid_range_scanner;

    localparam int W      = 40;
    localparam int SUM_W  = 56;
    localparam int CNT_W  = 24;
    localparam int SUM_W2 = 12;

    logic              clk = 1'b0;
    logic              rst_n, start, mode, accum;
    logic [3:0]        dig_len;
    logic [W-1:0]      lo, hi;
    logic              busy, done, ovf, err;
    logic [SUM_W-1:0]  sum_out;
    logic [CNT_W-1:0]  cnt_out;
    logic              busy2, done2, ovf2, err2;
    logic [SUM_W2-1:0] sum2;
    logic [CNT_W-1:0]  cnt2;

    always #5 clk = ~clk;

    invalid_range_scanner #(.W(W), .MAX_DIG(10), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .accum(accum),
        .dig_len(dig_len), .lo(lo), .hi(hi), .busy(busy), .done(done),
        .sum_out(sum_out), .cnt_out(cnt_out), .ovf(ovf), .err(err)
    );

    invalid_range_scanner #(.W(W), .MAX_DIG(10), .SUM_W(SUM_W2), .CNT_W(CNT_W)) dutNarrow (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .accum(accum),
        .dig_len(dig_len), .lo(lo), .hi(hi), .busy(busy2), .done(done2),
        .sum_out(sum2), .cnt_out(cnt2), .ovf(ovf2), .err(err2)
    );

    typedef struct {
        string           name;
        longint unsigned sum;
        int unsigned     cnt;
        bit              err;
        int              lat;
        bit              ovf1;
        bit              ovf2;
    } exp_t;

    exp_t            sbq[$];
    longint unsigned mSum;
    int unsigned     mCnt;
    bit              mOvf1, mOvf2;
    int              nCompared = 0;
    int              nMismatch = 0;

    function automatic longint unsigned pw(input int n);
        longint unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic bit isPrime(input int q);
        if (q < 2) return 0;
        for (int d = 2; d < q; d++) if (q % d == 0) return 0;
        return 1;
    endfunction

    // x must be some block of p digits written L/p times.
    function automatic bit isRep(input longint unsigned x, input int L, input bit md);
        longint unsigned blk, y;
        for (int p = 1; p < L; p++) begin
            if (L % p != 0) continue;
            if (!md && 2 * p != L) continue;
            blk = x % pw(p);
            y = 0;
            for (int i = 0; i < L / p; i++) y = y * pw(p) + blk;
            if (y == x) return 1;
        end
        return 0;
    endfunction

    function automatic int expLat(input int L, input bit md);
        int ps[$];
        int qs[$];
        int lat;
        if (L < 1 || L > 10) return 1;
        if (!md) begin
            if (L % 2 == 0) ps.push_back(L / 2);
        end else begin
            for (int q = 2; q <= L; q++) if (L % q == 0 && isPrime(q)) qs.push_back(q);
            foreach (qs[i]) ps.push_back(L / qs[i]);
            if (qs.size() == 2) ps.push_back(L / (qs[0] * qs[1]));
        end
        if (ps.size() == 0) return 2;
        lat = 1;
        foreach (ps[i]) lat += 1 + 9 * int'(pw(ps[i] - 1));
        return lat;
    endfunction

    task automatic pushExp(input string name, input bit md, input bit acc, input int L,
                           input longint unsigned l, input longint unsigned h);
        exp_t e;
        longint unsigned first, last;
        if (!acc) begin
            mSum = 0; mCnt = 0; mOvf1 = 0; mOvf2 = 0;
        end
        if (L >= 1 && L <= 10) begin
            first = (l > pw(L - 1)) ? l : pw(L - 1);
            last  = (h < pw(L) - 1) ? h : pw(L) - 1;
            for (longint unsigned x = first; x <= last; x++) begin
                if (isRep(x, L, md)) begin
                    mSum += x;
                    mCnt++;
                end
            end
        end
        if (mSum >= 64'd4096) mOvf2 = 1;
        if (mSum >= (64'd1 << 56)) mOvf1 = 1;
        e.name = name; e.sum = mSum; e.cnt = mCnt; e.err = !(L >= 1 && L <= 10);
        e.lat = expLat(L, md); e.ovf1 = mOvf1; e.ovf2 = mOvf2;
        sbq.push_back(e);
    endtask

    task automatic startJob(input string name, input bit md, input bit acc, input int L,
                            input longint unsigned l, input longint unsigned h, input int hold);
        pushExp(name, md, acc, L, l, h);
        @(negedge clk);
        mode = md; accum = acc; dig_len = 4'(L); lo = l[W-1:0]; hi = h[W-1:0];
        start = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called one step after the accept edge; n counts cycles since accept.
    task automatic waitDone(input int glitchAt);
        exp_t e;
        int   n = 1;
        while (!done && n < 20000) begin
            if (n == glitchAt) begin
                nCompared++;
                if (busy !== 1'b1) begin
                    nMismatch++;
                    $display("FAIL busy_mid: got %0b expected 1", busy);
                end
                start = 1'b1; mode = ~mode; dig_len = 4'd3; accum = 1'b0; lo = '0; hi = '1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        if (sbq.size() == 0) begin
            nCompared++; nMismatch++;
            $display("FAIL scoreboard_empty: got no entry expected one");
            return;
        end
        e = sbq.pop_front();
        nCompared++;
        if (!done) begin
            nMismatch++;
            $display("FAIL %s timeout: got no done after %0d cycles expected %0d", e.name, n, e.lat);
            return;
        end
        if (n !== e.lat) begin
            nMismatch++;
            $display("FAIL %s latency: got %0d expected %0d", e.name, n, e.lat);
        end
        nCompared++;
        if (sum_out !== e.sum[SUM_W-1:0]) begin
            nMismatch++;
            $display("FAIL %s sum: got %0d expected %0d", e.name, sum_out, e.sum[SUM_W-1:0]);
        end
        nCompared++;
        if (cnt_out !== e.cnt[CNT_W-1:0]) begin
            nMismatch++;
            $display("FAIL %s cnt: got %0d expected %0d", e.name, cnt_out, e.cnt[CNT_W-1:0]);
        end
        nCompared++;
        if (err !== e.err || err2 !== e.err) begin
            nMismatch++;
            $display("FAIL %s err: got %0b/%0b expected %0b", e.name, err, err2, e.err);
        end
        nCompared++;
        if (ovf !== e.ovf1) begin
            nMismatch++;
            $display("FAIL %s ovf: got %0b expected %0b", e.name, ovf, e.ovf1);
        end
        nCompared++;
        if (sum2 !== e.sum[SUM_W2-1:0] || cnt2 !== e.cnt[CNT_W-1:0]) begin
            nMismatch++;
            $display("FAIL %s narrow_totals: got %0d/%0d expected %0d/%0d", e.name, sum2, cnt2,
                     e.sum[SUM_W2-1:0], e.cnt[CNT_W-1:0]);
        end
        nCompared++;
        if (ovf2 !== e.ovf2) begin
            nMismatch++;
            $display("FAIL %s narrow_ovf: got %0b expected %0b", e.name, ovf2, e.ovf2);
        end
        nCompared++;
        if (busy !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b1) begin
            nMismatch++;
            $display("FAIL %s busy_at_done: got busy %0b/%0b done2 %0b expected 0/0 1",
                     e.name, busy, busy2, done2);
        end
    endtask

    task automatic endJob();
        @(posedge clk);
        #1;
        nCompared++;
        if (done !== 1'b0) begin
            nMismatch++;
            $display("FAIL done_pulse: got %0b expected 0", done);
        end
    endtask

    task automatic doJob(input string name, input bit md, input bit acc, input int L,
                         input longint unsigned l, input longint unsigned h);
        startJob(name, md, acc, L, l, h, 1);
        waitDone(0);
        endJob();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; accum = 1'b0; dig_len = 4'd0; lo = '0; hi = '0;
        mSum = 0; mCnt = 0; mOvf1 = 0; mOvf2 = 0;
        repeat (3) @(posedge clk);
        #1;
        nCompared++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || ovf !== 1'b0) begin
            nMismatch++;
            $display("FAIL reset_flags: got busy %0b done %0b err %0b ovf %0b expected 0", busy, done, err, ovf);
        end
        nCompared++;
        if (sum_out !== '0 || cnt_out !== '0) begin
            nMismatch++;
            $display("FAIL reset_totals: got %0d/%0d expected 0/0", sum_out, cnt_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        doJob("m0_L2_single", 1'b0, 1'b0, 2, 10, 11);
        doJob("m0_L2_accum", 1'b0, 1'b1, 2, 10, 99);
    endtask

    task automatic test_mode1();
        doJob("m1_L6_full", 1'b1, 1'b0, 6, 100000, 999999);
        doJob("m0_L6_full", 1'b0, 1'b0, 6, 100000, 999999);
    endtask

    task automatic test_overflow();
        doJob("ovf_sticky", 1'b0, 1'b1, 2, 10, 11);
        doJob("ovf_clear", 1'b0, 1'b0, 2, 10, 11);
    endtask

    task automatic test_odd_and_bounds();
        doJob("m0_L3_empty", 1'b0, 1'b0, 3, 100, 999);
        doJob("m0_lo_gt_hi", 1'b0, 1'b0, 2, 50, 20);
        doJob("m0_L4_exact", 1'b0, 1'b0, 4, 1212, 1212);
        doJob("m1_L3_part", 1'b1, 1'b0, 3, 100, 200);
    endtask

    task automatic test_illegal();
        doJob("len0", 1'b0, 1'b1, 0, 10, 99);
        doJob("len11", 1'b1, 1'b1, 11, 10, 99);
    endtask

    task automatic test_start_while_busy();
        startJob("busy_ignore", 1'b0, 1'b0, 2, 10, 99, 1);
        waitDone(5);
        endJob();
    endtask

    task automatic test_back_to_back();
        startJob("b2b_first", 1'b0, 1'b0, 2, 10, 33, 1);
        waitDone(0);
        // Start held across the done cycle: only the following edge may accept it.
        startJob("b2b_second", 1'b0, 1'b1, 2, 44, 55, 2);
        waitDone(0);
        endJob();
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        mode = 1'b1; accum = 1'b0; dig_len = 4'd6; lo = 40'd100000; hi = 40'd999999;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        nCompared++;
        if (busy !== 1'b1) begin
            nMismatch++;
            $display("FAIL busy_before_rst: got %0b expected 1", busy);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        nCompared++;
        if (busy !== 1'b0 || done !== 1'b0 || sum_out !== '0 || cnt_out !== '0 || ovf2 !== 1'b0) begin
            nMismatch++;
            $display("FAIL mid_reset: got busy %0b done %0b sum %0d cnt %0d ovf2 %0b expected all 0",
                     busy, done, sum_out, cnt_out, ovf2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mSum = 0; mCnt = 0; mOvf1 = 0; mOvf2 = 0;
        doJob("after_reset", 1'b0, 1'b0, 2, 10, 11);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mode1();
        test_overflow();
        test_odd_and_bounds();
        test_illegal();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
